wb_port_arbiter: RTL
====================

# wb_port_arbiter

Arbiter and sequencer for the register-file write-back port. Several write-back sources (ALU result, load path, HI/LO moves, shifter, constant/link paths) request the single write port. The block grants one source per cycle and drives the memToReg mux selector, `RegWrite` and `WriteReg`. It sits between the control unit's per-source write requests and the memToReg mux / register bank, and serializes write-backs with bounded waiting.

## Interface
Parameters:
- `N`, 4: number of requesters; valid range 2..8.
- `MAX_WAIT`, 7: wait cycles after which a pending requester becomes urgent; valid range 1..15.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req` in N: per-requester write request, level.
- `sel_in` in 4N: memToReg selector code of requester i in bits [4i+3:4i].
- `dst_in` in 5N: destination register of requester i in bits [5i+4:5i].
- `grant` out N: registered one-hot grant; high for exactly one cycle per write.
- `seletor` out 4: memToReg mux selector.
- `RegWrite` out 1: register-bank write enable.
- `WriteReg` out 5: register-bank write address.
- `sel_err` out 1: sticky flag, set when an invalid selector code is granted.

## Operation
- Valid selector codes are 0..10. Codes 11..15 are invalid.
- Eligibility: requester i is eligible when `req[i]`=1 and `grant[i]`=0 in the current cycle. A just-granted requester is masked for one cycle.
- Aging: each requester has a 4-bit wait counter.
  - Increments, saturating at `MAX_WAIT`, each cycle the requester is eligible and not selected.
  - Clears when the requester is granted or `req[i]`=0.
  - Requester i is urgent when its counter equals `MAX_WAIT`.
- Selection each cycle: if any eligible requester is urgent, choose the lowest-index urgent requester. Otherwise apply the base policy (see Configuration).
- On selection of i, the next cycle shows:
  - `grant`=1<<i
  - `seletor`=sel_i
  - `WriteReg`=dst_i
  - `RegWrite`=1
- Exceptions to the above:
  - dst_i = 0: `RegWrite`=0; grant is still issued, so the write to $zero is dropped.
  - sel_i ≥ 11: `RegWrite`=0; grant is still issued; `sel_err` is set and held until `reset`.
- No eligible requester: `grant`=0 and `RegWrite`=0. `seletor` and `WriteReg` hold their last values.
- Requester contract:
  - Hold `req`, `sel_in` and `dst_in` stable from assertion until grant is observed.
  - Deassert `req` in the grant cycle, or keep it asserted to request another write.

## Timing
- Latency: request sampled at edge k produces outputs valid in cycle k+1. With no contention, the write occurs 1 cycle after `req` rises.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Throughput: one write per cycle across requesters. The same requester gets at most one grant every 2 cycles, because of the one-cycle mask.
- Worst-case wait for any requester is bounded by `MAX_WAIT` + N cycles.
- Reset values: `grant`=0, `RegWrite`=0, `seletor`=0, `WriteReg`=0, `sel_err`=0. All wait counters and the round-robin pointer are 0.
- Reset mid-operation: pending state is discarded. Requests still asserted are re-arbitrated from the first edge after `reset` falls, with counters restarting at 0.
- `req[i]` dropping before grant: the request is withdrawn and its counter is cleared.

## Configuration
- `WB_RR_EN` defined: the base policy is round-robin.
  - A pointer register holds the index after the last granted requester, modulo N.
  - Search starts at the pointer and wraps.
  - The pointer updates on every grant, including urgent and dropped ($zero / invalid) grants.
  - The pointer does not update on idle cycles.
- `WB_RR_EN` undefined: the base policy is fixed priority, lowest index first, and no pointer register exists. Aging applies in both builds.

## Test plan
- Single request: `req`=0001, `sel_in[3:0]`=1, `dst_in[4:0]`=8 -> next cycle `grant`=0001, `seletor`=1, `WriteReg`=8, `RegWrite`=1; following cycle `grant`=0000, `RegWrite`=0.
- Contention, fixed build: `req`=1111 held -> grant order 0001, 0010, 0001, 0010, …, with requesters 2 and 3 granted once their counters reach 7.
  - Neither requester 2 nor 3 waits more than 11 cycles.
- Contention, `WB_RR_EN` build: `req`=1111 held -> grants 0001, 0010, 0100, 1000 repeating.
- $zero and invalid selector:
  - dst=0, sel=2 -> grant issued, `RegWrite`=0.
  - sel=12, dst=5 -> grant issued, `RegWrite`=0, `sel_err`=1, staying 1 until `reset`.
- Reset mid-operation: `req`=0110 with counters nonzero, assert `reset` for 1 cycle -> all outputs 0 during reset; first grant is 0010 one cycle after `reset` falls.
- Withdrawal: requester 3 waits 4 cycles under contention, then drops `req` -> counter clears; on re-assert it waits a full `MAX_WAIT` again before becoming urgent.

Source files
------------

// File: rtl/wb_port_arbiter.sv
// Write-back port arbiter: one registered grant per cycle, aging-based urgency, $zero / bad-selector write suppression.
// Define WB_RR_EN for a round-robin base policy; otherwise the base policy is fixed lowest-index priority.
module wb_port_arbiter #(
    parameter int N        = 4,
    parameter int MAX_WAIT = 7
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic [4*N-1:0] sel_in,
    input  logic [5*N-1:0] dst_in,
    output logic [N-1:0]   grant,
    output logic [3:0]     seletor,
    output logic           RegWrite,
    output logic [4:0]     WriteReg,
    output logic           sel_err
);
    localparam int         IW         = $clog2(N);
    localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);
    localparam logic [3:0] SEL_MAX_C  = 4'd10;

    function automatic logic sel_valid(input logic [3:0] code);
        return (code <= SEL_MAX_C);
    endfunction

    logic [N-1:0]      grant_q, grant_d;
    logic [3:0]        seletor_q, seletor_d;
    logic              regwrite_q, regwrite_d;
    logic [4:0]        writereg_q, writereg_d;
    logic              sel_err_q, sel_err_d;
    logic [N-1:0][3:0] wait_q, wait_d;

    logic [N-1:0]      eligible_s;
    logic [N-1:0]      urgent_s;
    logic [N-1:0]      sel_oh_s;
    logic [IW-1:0]     urg_pick_s;
    logic [IW-1:0]     base_pick_s;
    logic [IW-1:0]     sel_idx_s;
    logic              found_s;
    logic              urg_any_s;
    logic [3:0]        sel_code_s;
    logic [4:0]        dst_code_s;

    // Eligibility, urgency and the lowest-index urgent requester.
    always_comb begin
        eligible_s = req & ~grant_q;
        urgent_s   = '0;
        urg_pick_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            urgent_s[i] = eligible_s[i] && (wait_q[i] == MAX_WAIT_C);
            urg_pick_s  = urgent_s[i] ? IW'(i) : urg_pick_s;
        end
        urg_any_s = |urgent_s;
    end

`ifdef WB_RR_EN
    logic [IW-1:0] ptr_q, ptr_d, rr_idx_s;

    // Search from the pointer upward with wrap; descending loop leaves the pointer slot with top priority.
    always_comb begin
        base_pick_s = '0;
        rr_idx_s    = '0;
        for (int k = N - 1; k >= 0; k--) begin
            rr_idx_s    = IW'((int'(ptr_q) + k) % N);
            base_pick_s = eligible_s[rr_idx_s] ? rr_idx_s : base_pick_s;
        end
    end

    // Pointer moves past every granted requester, urgent or dropped grants included.
    always_comb begin
        ptr_d = ptr_q;
        if (found_s) begin
            ptr_d = (sel_idx_s == IW'(N - 1)) ? '0 : sel_idx_s + IW'(1);
        end else begin
            ptr_d = ptr_q;
        end
    end

    // Round-robin pointer register.
    always_ff @(posedge clk) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end
`else
    // Fixed priority: lowest eligible index.
    always_comb begin
        base_pick_s = '0;
        for (int i = N - 1; i >= 0; i--) begin
            base_pick_s = eligible_s[i] ? IW'(i) : base_pick_s;
        end
    end
`endif

    // Final winner and its selector / destination fields.
    always_comb begin
        found_s    = |eligible_s;
        sel_idx_s  = urg_any_s ? urg_pick_s : base_pick_s;
        sel_oh_s   = found_s ? (N'(1) << sel_idx_s) : '0;
        sel_code_s = '0;
        dst_code_s = '0;
        for (int i = 0; i < N; i++) begin
            sel_code_s = (sel_idx_s == IW'(i)) ? sel_in[4*i +: 4] : sel_code_s;
            dst_code_s = (sel_idx_s == IW'(i)) ? dst_in[5*i +: 5] : dst_code_s;
        end
    end

    // Next-state for outputs and wait counters; writes to $zero or with a bad selector are granted but dropped.
    always_comb begin
        grant_d    = sel_oh_s;
        seletor_d  = seletor_q;
        writereg_d = writereg_q;
        regwrite_d = 1'b0;
        sel_err_d  = sel_err_q;
        wait_d     = wait_q;
        if (found_s) begin
            seletor_d  = sel_code_s;
            writereg_d = dst_code_s;
            regwrite_d = (dst_code_s != 5'd0) && sel_valid(sel_code_s);
            sel_err_d  = sel_err_q | ~sel_valid(sel_code_s);
        end else begin
            regwrite_d = 1'b0;
        end
        for (int i = 0; i < N; i++) begin
            if (!req[i] || sel_oh_s[i]) begin
                wait_d[i] = 4'd0;
            end else if (eligible_s[i]) begin
                wait_d[i] = (wait_q[i] >= MAX_WAIT_C) ? MAX_WAIT_C : wait_q[i] + 4'd1;
            end else begin
                wait_d[i] = wait_q[i];
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            grant_q    <= '0;
            seletor_q  <= 4'd0;
            regwrite_q <= 1'b0;
            writereg_q <= 5'd0;
            sel_err_q  <= 1'b0;
            wait_q     <= '0;
        end else begin
            grant_q    <= grant_d;
            seletor_q  <= seletor_d;
            regwrite_q <= regwrite_d;
            writereg_q <= writereg_d;
            sel_err_q  <= sel_err_d;
            wait_q     <= wait_d;
        end
    end

    assign grant    = grant_q;
    assign seletor  = seletor_q;
    assign RegWrite = regwrite_q;
    assign WriteReg = writereg_q;
    assign sel_err  = sel_err_q;

endmodule
